// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
package spi_regfile_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    FULL,
    OVER
  } state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one async SPI pin with edge pulses
// derived from a history flop behind the last sync stage.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q, chain_d;
  logic              hist_q, hist_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
    hist_d  = chain_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q <= {STAGES{RST_VAL}};
      hist_q  <= RST_VAL;
    end else begin
      chain_q <= chain_d;
      hist_q  <= hist_d;
    end
  end

  assign q    = chain_q[STAGES-1];
  assign rise = q & ~hist_q;
  assign fall = ~q & hist_q;

endmodule

// File: rtl/spi_regfile_rw.sv
// SPI mode-0 register file: write frames update registers,
// read frames shift the addressed register out on CIPO.
module spi_regfile_rw
  import spi_regfile_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic [NUM_REGS-1:0]        wr_stb,
  output logic                       frame_err
);

  localparam int FL    = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(FL + 2);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic ncs_s, ncs_rise, ncs_fall;
  logic copi_s, copi_rise_unused, copi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk),
    .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
    .clk(clk), .rst_n(rst_n), .d(ncs),
    .q(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
    .clk(clk), .rst_n(rst_n), .d(copi),
    .q(copi_s), .rise(copi_rise_unused), .fall(copi_fall_unused)
  );

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_nxt;
  logic [FL-1:0]       sh_q, sh_d, sh_nxt;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                rd_q, rd_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                err_q, err_d;
  logic                frame_err_q;
  logic                samp, wa_hit;
  logic [DATA_W-1:0]   rd_val;

  function automatic state_e state_of(input logic [CNT_W-1:0] c);
    if (c == '0) return CMD;
    if (c < CNT_W'(1 + ADDR_W)) return ADDR;
    if (c < CNT_W'(FL)) return DATA;
    if (c == CNT_W'(FL)) return FULL;
    return OVER;
  endfunction

  // The bit is counted before commit, so sclk/ncs rising together still count.
  assign samp    = (state_q != IDLE) && sclk_rise && !ncs_fall;
  assign sh_nxt  = samp ? {sh_q[FL-2:0], copi_s} : sh_q;
  assign cnt_nxt = (samp && cnt_q != CNT_W'(FL + 1))
                 ? cnt_q + CNT_W'(1) : cnt_q;

  always_comb begin
    rd_val = '0;
    wa_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sh_nxt[ADDR_W-1:0] == ADDR_W'(i))
        rd_val = regs_out[i*DATA_W +: DATA_W];
      if (sh_nxt[DATA_W +: ADDR_W] == ADDR_W'(i))
        wa_hit = 1'b1;
    end
  end

  always_comb begin
    state_e st;
    st        = samp ? state_of(cnt_nxt) : state_q;
    state_d   = state_q;
    cnt_d     = cnt_nxt;
    sh_d      = sh_nxt;
    out_d     = out_q;
    rd_d      = rd_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    if (ncs_fall) begin
      state_d = CMD;
      cnt_d   = '0;
      sh_d    = '0;
      out_d   = '0;
      rd_d    = 1'b0;
    end else if (state_q != IDLE) begin
      state_d = st;
      if (samp && cnt_nxt == CNT_W'(1 + ADDR_W)
          && sh_nxt[ADDR_W] == RW_READ) begin
        out_d = rd_val;
        rd_d  = 1'b1;
      end else if (sclk_fall && rd_q && state_q == DATA
                   && cnt_q > CNT_W'(1 + ADDR_W)) begin
        out_d = {out_q[DATA_W-2:0], 1'b0};
      end
      if (ncs_rise) begin
        state_d = IDLE;
        unique case (1'b1)
          (st != FULL): err_d = 1'b1;
          (st == FULL && sh_nxt[FL-1] == RW_WRITE && wa_hit): begin
            wr_en_d   = 1'b1;
            wr_addr_d = sh_nxt[DATA_W +: ADDR_W];
            wr_data_d = sh_nxt[DATA_W-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      out_q       <= '0;
      rd_q        <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      out_q       <= out_d;
      rd_q        <= rd_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      err_q       <= err_d;
      frame_err_q <= err_q;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic              hit;
    logic [DATA_W-1:0] r_q, r_d;
    logic              stb_q;

    assign hit = wr_en_q && (wr_addr_q == ADDR_W'(i));

    always_comb r_d = hit ? wr_data_q : r_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_q   <= RESET_VAL[i*DATA_W +: DATA_W];
        stb_q <= 1'b0;
      end else begin
        r_q   <= r_d;
        stb_q <= hit;
      end
    end

    assign regs_out[i*DATA_W +: DATA_W] = r_q;
    assign wr_stb[i] = stb_q;
  end

  assign cipo = (rd_q && state_q == DATA && !ncs_s)
              ? out_q[DATA_W-1] : 1'b0;
  assign cipo_oe   = ~ncs_s;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regfile_rw.sv
// Directed bench for spi_regfile_rw: writes, read-back,
// out-of-range addresses, bad frame lengths, reset mid-frame.
module tb_spi_regfile_rw;

  localparam logic [39:0] RV = 40'h55_44_33_22_11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        ncs = 1'b1;
  logic        copi = 1'b0;
  logic        cipo, cipo_oe, frame_err;
  logic [39:0] regs_out;
  logic [4:0]  wr_stb;

  int checks = 0;
  int errors = 0;
  int stb_cycles = 0;
  int err_cycles = 0;
  logic [4:0] last_stb = '0;

  spi_regfile_rw #(
    .ADDR_W(7), .DATA_W(8), .NUM_REGS(5),
    .SYNC_STAGES(2), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .ncs(ncs),
    .copi(copi), .cipo(cipo), .cipo_oe(cipo_oe),
    .regs_out(regs_out), .wr_stb(wr_stb), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_stb != '0) begin
        stb_cycles++;
        last_stb = wr_stb;
      end
      if (frame_err) err_cycles++;
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    @(negedge clk);
    stb_cycles = 0;
    err_cycles = 0;
    last_stb   = '0;
  endtask

  function automatic logic [31:0] fr(input logic rw,
                                     input logic [6:0] a,
                                     input logic [7:0] d);
    return {16'h0, rw, a, d};
  endfunction

  task automatic send_bit(input logic b, input int i,
                          inout logic [7:0] rd);
    copi = b;
    repeat (4) @(negedge clk);
    if (i >= 8 && i < 16) rd = {rd[6:0], cipo};
    sclk = 1'b1;
    repeat (8) @(negedge clk);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame(input int n, input logic [31:0] bits,
                       output logic [7:0] rd, output logic oe);
    logic [7:0] r;
    r = '0;
    oe = 1'b0;
    @(negedge clk);
    ncs = 1'b0;
    repeat (8) @(negedge clk);
    oe = cipo_oe;
    for (int i = 0; i < n; i++) send_bit(bits[n-1-i], i, r);
    ncs = 1'b1;
    copi = 1'b0;
    repeat (12) @(negedge clk);
    rd = r;
  endtask

  initial begin
    logic [7:0] rd;
    logic       oe;
    logic [7:0] junk;

    repeat (5) @(negedge clk);
    check("rst_regs", regs_out, RV);
    check("rst_oe", cipo_oe, 1'b0);
    check("rst_cipo", cipo, 1'b0);
    check("rst_stb", wr_stb, 5'b0);
    check("rst_err", frame_err, 1'b0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_regs", regs_out, RV);
    check("idle_oe", cipo_oe, 1'b0);
    check("idle_stb", stb_cycles, 0);

    clr();
    frame(16, fr(1'b1, 7'h02, 8'hA5), rd, oe);
    check("w2_oe_mid", oe, 1'b1);
    check("w2_regs", regs_out, 40'h55_44_A5_22_11);
    check("w2_stb_cycles", stb_cycles, 1);
    check("w2_stb_val", last_stb, 5'b00100);
    check("w2_err", err_cycles, 0);
    check("w2_oe_after", cipo_oe, 1'b0);

    clr();
    frame(16, fr(1'b1, 7'h04, 8'h3C), rd, oe);
    check("w4_regs", regs_out, 40'h3C_44_A5_22_11);
    check("w4_stb", last_stb, 5'b10000);
    clr();
    frame(16, fr(1'b0, 7'h04, 8'h00), rd, oe);
    check("r4_data", rd, 8'h3C);
    check("r4_regs", regs_out, 40'h3C_44_A5_22_11);
    check("r4_stb", stb_cycles, 0);
    check("r4_err", err_cycles, 0);
    check("r4_cipo_idle", cipo, 1'b0);
    frame(16, fr(1'b0, 7'h02, 8'hFF), rd, oe);
    check("r2_data", rd, 8'hA5);
    frame(16, fr(1'b0, 7'h03, 8'h00), rd, oe);
    check("r3_data", rd, 8'h44);

    clr();
    frame(16, fr(1'b1, 7'h7F, 8'hFF), rd, oe);
    check("w7f_regs", regs_out, 40'h3C_44_A5_22_11);
    check("w7f_stb", stb_cycles, 0);
    check("w7f_err", err_cycles, 0);
    frame(16, fr(1'b0, 7'h7F, 8'h00), rd, oe);
    check("r7f_data", rd, 8'h00);

    clr();
    frame(15, fr(1'b1, 7'h00, 8'h99) >> 1, rd, oe);
    check("short_err", err_cycles, 1);
    check("short_stb", stb_cycles, 0);
    check("short_reg0", regs_out[7:0], 8'h11);
    clr();
    frame(17, fr(1'b1, 7'h00, 8'h99) << 1, rd, oe);
    check("long_err", err_cycles, 1);
    check("long_stb", stb_cycles, 0);
    check("long_reg0", regs_out[7:0], 8'h11);

    clr();
    @(negedge clk);
    ncs = 1'b0;
    repeat (8) @(negedge clk);
    junk = '0;
    for (int i = 0; i < 12; i++)
      send_bit(fr(1'b1, 7'h01, 8'h77) >> (15 - i), i, junk);
    rst_n = 1'b0;
    ncs = 1'b1;
    copi = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_regs", regs_out, RV);
    check("abort_stb", stb_cycles, 0);
    check("abort_err", err_cycles, 0);
    clr();
    frame(16, fr(1'b1, 7'h01, 8'h77), rd, oe);
    check("post_regs", regs_out, 40'h55_44_33_77_11);
    check("post_stb", last_stb, 5'b00010);
    check("post_stb_cycles", stb_cycles, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
